// File: rtl/store_narrower_if.sv
// Store request / data RAM bundle between the MEM stage, store_narrower and the
// word-organised data memory.
interface store_narrower_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic [29:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;

    // Requester and RAM side of the block.
    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rdata,
        input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, err
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rdata,
        output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, err
    );
endinterface

// File: rtl/store_narrower.sv
// Narrows a register value to a byte/halfword/word store into a RAM without byte
// enables; sub-word stores run a read-modify-write, word stores write directly.
module store_narrower #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input logic        clk,
    input logic        reset,
    store_narrower_if.slave bus
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MRG,
        WR,
        ERR
    } state_t;

    state_t      state, state_nxt;

    logic [1:0]  lat_lo;
    logic        lat_half;
    logic [15:0] lat_data;
    logic        lat_ld;

    logic [29:0] addr_q, addr_nxt;
    logic [31:0] wdata_q, wdata_nxt;
    logic        rd_q, rd_nxt;
    logic        wr_q, wr_nxt;
    logic        done_q, done_nxt;
    logic        err_q, err_nxt;

    logic        req_bad;
    logic        half_lane;
    logic [1:0]  byte_lane;
    logic [31:0] merged;

    always_comb begin
        req_bad = 1'b0;
        if (bus.req_size == 2'b11) begin
            req_bad = 1'b1;
        end else if (bus.req_size == SIZE_HALF && bus.req_addr[0]) begin
            req_bad = 1'b1;
        end else if (bus.req_size == SIZE_WORD && bus.req_addr[1:0] != 2'b00) begin
            req_bad = 1'b1;
        end
    end

    // Big-endian lane order mirrors the little-endian lane index within the word.
    assign half_lane = lat_lo[1] ^ BIG_ENDIAN;
    assign byte_lane = lat_lo ^ {2{BIG_ENDIAN}};

    always_comb begin
        merged = bus.mem_rdata;
        if (lat_half) begin
            merged[{half_lane, 4'b0000} +: 16] = lat_data;
        end else begin
            merged[{byte_lane, 3'b000} +: 8] = lat_data[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lat_ld    = 1'b0;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    lat_ld = 1'b1;
                    if (req_bad) begin
                        state_nxt = ERR;
                        err_nxt   = 1'b1;
                    end else if (bus.req_size == SIZE_WORD) begin
                        state_nxt = WR;
                        addr_nxt  = bus.req_addr[31:2];
                        wdata_nxt = bus.req_data;
                        wr_nxt    = 1'b1;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = RD;
                        addr_nxt  = bus.req_addr[31:2];
                        rd_nxt    = 1'b1;
                    end
                end
            end
            RD: begin
                state_nxt = MRG;
            end
            MRG: begin
                state_nxt = WR;
                wdata_nxt = merged;
                wr_nxt    = 1'b1;
                done_nxt  = 1'b1;
            end
            WR: begin
                state_nxt = IDLE;
            end
            ERR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Strobes are computed from the next state so every output comes straight off a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            rd_q    <= rd_nxt;
            wr_q    <= wr_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_lo   <= 2'b00;
            lat_half <= 1'b0;
            lat_data <= '0;
        end else if (lat_ld) begin
            lat_lo   <= bus.req_addr[1:0];
            lat_half <= (bus.req_size == SIZE_HALF);
            lat_data <= bus.req_data[15:0];
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_rd    = rd_q;
    assign bus.mem_wr    = wr_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    logic unused_size_byte;
    assign unused_size_byte = (SIZE_BYTE == 2'b00);

endmodule
